ones_count_sequencer: RTL and testbench

//  Sequencer for the 3-input transistor-level ones counter (OC) cell.
//  - Accepts a WIDTH-bit word over a valid/ready handshake.
//  - Feeds the word to one external OC cell 3 bits at a time (oc_a/oc_b/oc_c).
//  - After a programmable settle time, samples the cell's 2-bit count {oc_y1,oc_y0}
//    and accumulates it; returns the popcount over a second valid/ready handshake.
//  - Sits between a word producer and a single shared OC cell instance.

---
 rtl/ones_count_sequencer.sv | 108 ++++++++++
 tb/tb_ones_count_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_sequencer.sv
// Sequencer that streams a word through one shared 3-input ones-counter cell,
// three bits per chunk, and accumulates the sampled 2-bit counts into a popcount.
module ones_count_sequencer #(
    parameter int  WIDTH         = 12,
    parameter int  SETTLE_CYCLES = 2,
    localparam int CW            = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             oc_a,
    output logic             oc_b,
    output logic             oc_c,
    input  logic             oc_y1,
    input  logic             oc_y0,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CW-1:0]    count,
    output logic             busy
);

    localparam int NCHUNK = (WIDTH + 2) / 3;
    localparam int SW     = 3 * NCHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int TW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_CHUNK    = IW'(NCHUNK - 1);
    localparam logic [TW-1:0] SETTLE_RELOAD = TW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [SW-1:0] sr;
    logic [SW-1:0] sr_next;
    logic [SW-1:0] data_pad;
    logic [IW-1:0] chunk_idx;
    logic [TW-1:0] settle_ctr;
    logic          accept;
    logic          sample;
    logic          last;
    logic          handoff;

    always_comb begin
        data_pad              = '0;
        data_pad[WIDTH-1:0]   = data_in;
        sr_next               = sr >> 3;
        accept                = (state == IDLE) && start_valid;
        sample                = (state == SETTLE) && (settle_ctr == '0);
        last                  = (chunk_idx == LAST_CHUNK);
        handoff               = (state == DONE) && done_ready;
        state_nxt             = state;
        case (state)
            IDLE:    if (accept)          state_nxt = SETTLE;
            SETTLE:  if (sample && last)  state_nxt = DONE;
            DONE:    if (handoff)         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            count       <= '0;
            sr          <= '0;
            chunk_idx   <= '0;
            settle_ctr  <= '0;
            oc_a        <= 1'b0;
            oc_b        <= 1'b0;
            oc_c        <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_ready <= (state_nxt == IDLE);
            done_valid  <= (state_nxt == DONE);
            busy        <= (state_nxt != IDLE);
            if (accept) begin
                sr                 <= data_pad;
                count              <= '0;
                chunk_idx          <= '0;
                settle_ctr         <= SETTLE_RELOAD;
                {oc_c, oc_b, oc_a} <= data_pad[2:0];
            end else if (state == SETTLE) begin
                if (sample) begin
                    count <= count + CW'({oc_y1, oc_y0});
                    sr    <= sr_next;
                    if (last) begin
                        {oc_c, oc_b, oc_a} <= 3'b000;
                    end else begin
                        chunk_idx          <= chunk_idx + IW'(1);
                        settle_ctr         <= SETTLE_RELOAD;
                        {oc_c, oc_b, oc_a} <= sr_next[2:0];
                    end
                end else begin
                    settle_ctr <= settle_ctr - TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Self-checking bench for ones_count_sequencer: behavioural OC cells as peers,
// scoreboard queue of expected popcounts, one task per scenario.
module tb_ones_count_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=12 instance
    logic        start_valid, start_ready, done_valid, done_ready, busy;
    logic [11:0] data_in;
    logic        oc_a, oc_b, oc_c, oc_y1, oc_y0;
    logic [3:0]  count;

    // WIDTH=10 instance
    logic        sv10, sr10, dv10, dr10, busy10;
    logic [9:0]  d10;
    logic        a10, b10, c10, y1_10, y0_10;
    logic [3:0]  cnt10;

    // OC cell models: y1 = majority, y0 = parity
    assign oc_y1 = (oc_a & oc_b) | (oc_a & oc_c) | (oc_b & oc_c);
    assign oc_y0 = oc_a ^ oc_b ^ oc_c;
    assign y1_10 = (a10 & b10) | (a10 & c10) | (b10 & c10);
    assign y0_10 = a10 ^ b10 ^ c10;

    ones_count_sequencer #(.WIDTH(12), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .data_in(data_in),
        .oc_a(oc_a), .oc_b(oc_b), .oc_c(oc_c), .oc_y1(oc_y1), .oc_y0(oc_y0),
        .done_valid(done_valid), .done_ready(done_ready), .count(count), .busy(busy)
    );

    ones_count_sequencer #(.WIDTH(10), .SETTLE_CYCLES(2)) dut10 (
        .clk(clk), .rst(rst),
        .start_valid(sv10), .start_ready(sr10), .data_in(d10),
        .oc_a(a10), .oc_b(b10), .oc_c(c10), .oc_y1(y1_10), .oc_y0(y0_10),
        .done_valid(dv10), .done_ready(dr10), .count(cnt10), .busy(busy10)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int t_acc;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected end before 100000ns");
        $fatal(1);
    end

    task automatic accept_word(input logic [11:0] d);
        for (int k = 0; k < 40 && start_ready !== 1'b1; k++) @(negedge clk);
        n_checks++;
        if (start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: start_ready=%b expected 1", start_ready);
        end
        start_valid = 1'b1;
        data_in     = d;
        exp_q.push_back($countones(d));
        @(negedge clk);
        start_valid = 1'b0;
        t_acc       = cyc;
    endtask

    task automatic wait_done(input string name, input int lat);
        int exp;
        for (int k = 0; k < 40 && done_valid !== 1'b1; k++) @(negedge clk);
        n_checks++;
        if (done_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done_valid=%b expected 1", name, done_valid);
        end
        n_checks++;
        if (cyc - t_acc !== lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc - t_acc, lat);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if (count !== 4'(exp)) begin
            n_fail++;
            $display("FAIL %s_count: count=%0d expected %0d", name, count, exp);
        end
        n_checks++;
        if ({oc_c, oc_b, oc_a, busy, start_ready} !== 5'b00010) begin
            n_fail++;
            $display("FAIL %s_done_outputs: oc=%b busy=%b start_ready=%b expected oc=000 busy=1 start_ready=0",
                     name, {oc_c, oc_b, oc_a}, busy, start_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({done_valid, start_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_release: done_valid=%b start_ready=%b expected 0 1", name, done_valid, start_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_valid = 1'b0; data_in = '0; done_ready = 1'b1;
        sv10 = 1'b0; d10 = '0; dr10 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({start_ready, done_valid, busy, count, oc_c, oc_b, oc_a} !== {3'b100, 4'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b dvalid=%b busy=%b count=%0d oc=%b expected 1 0 0 0 000",
                     start_ready, done_valid, busy, count, {oc_c, oc_b, oc_a});
        end
        n_checks++;
        if ({sr10, dv10, busy10, cnt10} !== {3'b100, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_state_w10: ready=%b dvalid=%b busy=%b count=%0d expected 1 0 0 0",
                     sr10, dv10, busy10, cnt10);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_ones();
        done_ready = 1'b1;
        accept_word(12'hFFF);
        wait_done("all_ones", 8);
    endtask

    task automatic test_patterns();
        logic [11:0] d;
        accept_word(12'h000);
        wait_done("all_zero", 8);
        d = 12'hA5C;
        accept_word(d);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({oc_c, oc_b, oc_a} !== d[3*(i/2) +: 3]) begin
                n_fail++;
                $display("FAIL pattern_oc_cycle%0d: cba=%b expected %b", i, {oc_c, oc_b, oc_a}, d[3*(i/2) +: 3]);
            end
            @(negedge clk);
        end
        wait_done("pattern_a5c", 8);
    endtask

    task automatic test_stall();
        done_ready = 1'b0;
        accept_word(12'hFFF);
        for (int k = 0; k < 40 && done_valid !== 1'b1; k++) @(negedge clk);
        start_valid = 1'b1;
        data_in     = 12'h0F0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({done_valid, start_ready} !== 2'b10 || count !== 4'(exp_q[0])) begin
                n_fail++;
                $display("FAIL stall_hold%0d: dvalid=%b ready=%b count=%0d expected 1 0 %0d",
                         i, done_valid, start_ready, count, exp_q[0]);
            end
        end
        done_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({done_valid, start_ready} !== 2'b01 || count !== 4'(exp_q[0])) begin
            n_fail++;
            $display("FAIL stall_release: dvalid=%b ready=%b count=%0d expected 0 1 %0d",
                     done_valid, start_ready, count, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back($countones(data_in));
        @(negedge clk);
        start_valid = 1'b0;
        t_acc       = cyc;
        n_checks++;
        if ({busy, start_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_next_accept: busy=%b ready=%b expected 1 0", busy, start_ready);
        end
        wait_done("stall_next", 8);
    endtask

    task automatic test_reset_abort();
        done_ready = 1'b1;
        accept_word(12'hFFF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_checks++;
        if ({start_ready, done_valid, busy, count, oc_c, oc_b, oc_a} !== {3'b100, 4'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL abort_reset_state: ready=%b dvalid=%b busy=%b count=%0d oc=%b expected 1 0 0 0 000",
                     start_ready, done_valid, busy, count, {oc_c, oc_b, oc_a});
        end
        accept_word(12'h007);
        wait_done("after_abort", 8);
    endtask

    task automatic test_width10();
        logic [11:0] pad;
        int          exp;
        int          t10;
        pad = {2'b00, 10'h3FF};
        for (int k = 0; k < 40 && sr10 !== 1'b1; k++) @(negedge clk);
        sv10 = 1'b1;
        d10  = 10'h3FF;
        exp_q.push_back($countones(d10));
        @(negedge clk);
        sv10 = 1'b0;
        t10  = cyc;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({c10, b10, a10} !== pad[3*(i/2) +: 3]) begin
                n_fail++;
                $display("FAIL w10_oc_cycle%0d: cba=%b expected %b", i, {c10, b10, a10}, pad[3*(i/2) +: 3]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (dv10 !== 1'b1 || cyc - t10 !== 8) begin
            n_fail++;
            $display("FAIL w10_latency: dvalid=%b after %0d cycles expected 1 after 8", dv10, cyc - t10);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if (cnt10 !== 4'(exp)) begin
            n_fail++;
            $display("FAIL w10_count: count=%0d expected %0d", cnt10, exp);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc   = 0;
        int n_done  = 0;
        int last_a  = -1;
        bit pend    = 1'b0;
        int exp;
        done_ready  = 1'b1;
        start_valid = 1'b1;
        data_in     = 12'($urandom);
        for (int i = 0; i < 150 && n_done < 6; i++) begin
            if (done_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if (count !== 4'(exp)) begin
                    n_fail++;
                    $display("FAIL b2b_count%0d: count=%0d expected %0d", n_done, count, exp);
                end
                n_done++;
            end
            if (start_valid && start_ready === 1'b1) begin
                exp_q.push_back($countones(data_in));
                if (last_a >= 0) begin
                    n_checks++;
                    if (cyc - last_a !== 10) begin
                        n_fail++;
                        $display("FAIL b2b_spacing%0d: spacing=%0d expected 10", n_acc, cyc - last_a);
                    end
                end
                last_a = cyc;
                n_acc++;
                pend = 1'b1;
            end
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (n_acc == 6) start_valid = 1'b0;
                else            data_in = 12'($urandom);
            end
        end
        start_valid = 1'b0;
        n_checks++;
        if (n_done !== 6) begin
            n_fail++;
            $display("FAIL b2b_results: got %0d results expected 6", n_done);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_all_ones();
        test_patterns();
        test_stall();
        test_reset_abort();
        test_width10();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
